lsu_subword_ctrl: RTL

- Load/store sequencer placed directly upstream of the data memory, between the EX/MEM pipeline register and the memory block.
- Issues only word-aligned, full-word reads and writes to memory.
- Performs byte/halfword lane extraction with sign or zero extension for loads.
- Performs read-modify-write for SB/SH.
- Detects misaligned and unsupported accesses.
- Stalls the pipeline while a multi-cycle access is in flight.

---
 rtl/lsu_subword_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_subword_ctrl.sv
// Purpose : load/store sequencer in front of a word-only data memory; does
//           sub-word lane extract/extend for loads and read-modify-write for SB/SH.
// Latency : LW/LH/LB 3 cycles (2 stall); SB/SH 3 cycles (2 stall); SW and errors 1 cycle.
// Backpressure: raises stall to freeze the upstream pipeline while an access is in flight.
//
// Ports:
//   clk, reset                 pipeline clock, async active-high reset
//   req_valid/we/funct3/addr/wdata   request from EX/MEM (held stable while stall=1)
//   stall                      freeze PC, IF/ID, ID/EX, EX/MEM
//   resp_valid/resp_rdata/access_err completion strobe, registered load data, error flag
//   mem_read/mem_write/mem_addr/mem_funct3/mem_wd/mem_rd   word-aligned memory interface
module lsu_subword_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  access_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [2:0]            mem_funct3,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_WAIT   = 3'd1,
    LD_RESP   = 3'd2,
    RMW_WAIT  = 3'd3,
    RMW_WRITE = 3'd4
  } state_t;

  // Request copy taken on acceptance; later states work from this, not req_*.
  typedef struct packed {
    logic [2:0]            funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [15:0]           wdata;
  } req_t;

  state_t              state, next_state;
  req_t                lat;
  logic [DATA_W-1:0]   merge_buf;
  logic                req_err;
  logic                f3_ok;
  logic                align_ok;
  logic                is_sw;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;
  logic [DM_ADDRESS-1:0] cur_addr;

  // ---------------------------------------------------------------------
  // Request classification (only meaningful in IDLE)
  // ---------------------------------------------------------------------
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    case (req_funct3)
      F3_B:  f3_ok = 1'b1;
      F3_H: begin
        f3_ok    = 1'b1;
        align_ok = ~req_addr[0];
      end
      F3_W: begin
        f3_ok    = 1'b1;
        align_ok = (req_addr[1:0] == 2'b00);
      end
      // Unsigned variants exist only for loads.
      F3_BU: f3_ok = ~req_we;
      F3_HU: begin
        f3_ok    = ~req_we;
        align_ok = ~req_addr[0];
      end
      default: f3_ok = 1'b0;
    endcase
    req_err = ~(f3_ok & align_ok);
    is_sw   = req_we & (req_funct3 == F3_W);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid && !req_err) begin
          if (!req_we) begin
            next_state = LD_WAIT;
          end else if (!is_sw) begin
            next_state = RMW_WAIT;
          end
        end
      end
      LD_WAIT:   next_state = LD_RESP;
      LD_RESP:   next_state = IDLE;
      RMW_WAIT:  next_state = RMW_WRITE;
      RMW_WRITE: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Strobes are forced low while reset is held so that an
  // RMW interrupted by reset can never leak a write.
  // ---------------------------------------------------------------------
  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    access_err = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wd     = req_wdata;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              resp_valid = 1'b1;
              access_err = 1'b1;
            end else if (is_sw) begin
              mem_write  = 1'b1;
              resp_valid = 1'b1;
            end else begin
              // Loads and SB/SH both start with a word read.
              mem_read = 1'b1;
              stall    = 1'b1;
            end
          end
        end
        LD_WAIT:  stall = 1'b1;
        LD_RESP:  resp_valid = 1'b1;
        RMW_WAIT: stall = 1'b1;
        RMW_WRITE: begin
          mem_write  = 1'b1;
          mem_wd     = merge_buf;
          resp_valid = 1'b1;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // Memory always sees a word-aligned address and a word-size access.
  assign cur_addr   = (state == IDLE) ? req_addr : lat.addr;
  assign mem_addr   = {cur_addr[DM_ADDRESS-1:2], 2'b00};
  assign mem_funct3 = F3_W;

  // ---------------------------------------------------------------------
  // Lane extraction / merge, driven from the latched request
  // ---------------------------------------------------------------------
  always_comb begin
    case (lat.addr[1:0])
      2'd0:    byte_lane = mem_rd[7:0];
      2'd1:    byte_lane = mem_rd[15:8];
      2'd2:    byte_lane = mem_rd[23:16];
      default: byte_lane = mem_rd[31:24];
    endcase
    half_lane = lat.addr[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (lat.funct3)
      F3_B:    load_ext = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_ext = {{(DATA_W-8){1'b0}}, byte_lane};
      F3_H:    load_ext = {{(DATA_W-16){half_lane[15]}}, half_lane};
      F3_HU:   load_ext = {{(DATA_W-16){1'b0}}, half_lane};
      default: load_ext = mem_rd;
    endcase

    merged = mem_rd;
    if (lat.funct3 == F3_B) begin
      case (lat.addr[1:0])
        2'd0:    merged[7:0]   = lat.wdata[7:0];
        2'd1:    merged[15:8]  = lat.wdata[7:0];
        2'd2:    merged[23:16] = lat.wdata[7:0];
        default: merged[31:24] = lat.wdata[7:0];
      endcase
    end else if (lat.addr[1]) begin
      merged[31:16] = lat.wdata;
    end else begin
      merged[15:0] = lat.wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat        <= '0;
      merge_buf  <= '0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid && !req_err) begin
        lat <= '{funct3: req_funct3, addr: req_addr, wdata: req_wdata[15:0]};
      end
      // mem_rd is valid in the cycle after the read strobe, i.e. in the wait states.
      if (state == LD_WAIT) begin
        resp_rdata <= load_ext;
      end
      if (state == RMW_WAIT) begin
        merge_buf <= merged;
      end
    end
  end

endmodule
